// File: rtl/can_config_sequencer.sv
// Wishbone-master bring-up sequencer that writes the SJA1000 setup table (reset mode, CDR, BTR, ACR/AMR, run).
// Optional read-back verification of each non-MODE write is enabled by defining CAN_CFG_VERIFY_EN.
module can_config_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        ext_mode_i,
    input  logic        afm_i,
    input  logic [1:0]  sjw_i,
    input  logic [5:0]  brp_i,
    input  logic        sam_i,
    input  logic [3:0]  tseg1_i,
    input  logic [2:0]  tseg2_i,
    input  logic [31:0] acr_i,
    input  logic [31:0] amr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [4:0]  err_step_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STEP_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [STEP_W-1:0]  step;
    logic               rd_phase;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               ext_q;
    logic               afm_q;
    logic [7:0]         btr0_q;
    logic [7:0]         btr1_q;
    logic [31:0]        acr_q;
    logic [31:0]        amr_q;

    logic [STEP_W-1:0]  next_step;
    logic [STEP_W-1:0]  last_step;
    logic [7:0]         tbl_adr;
    logic [7:0]         tbl_dat;
    logic               need_rd;
    logic               rd_bad;

    assign next_step = step + STEP_W'(1);
    assign last_step = ext_q ? STEP_W'(12) : STEP_W'(6);

    // Register write table for the step after the current one
    always_comb begin
        tbl_adr = 8'h00;
        tbl_dat = 8'h00;
        if (ext_q) begin
            case (next_step)
                5'd0:  begin tbl_adr = 8'd0;  tbl_dat = 8'h01;        end
                5'd1:  begin tbl_adr = 8'd31; tbl_dat = 8'h80;        end
                5'd2:  begin tbl_adr = 8'd6;  tbl_dat = btr0_q;       end
                5'd3:  begin tbl_adr = 8'd7;  tbl_dat = btr1_q;       end
                5'd4:  begin tbl_adr = 8'd16; tbl_dat = acr_q[31:24]; end
                5'd5:  begin tbl_adr = 8'd17; tbl_dat = acr_q[23:16]; end
                5'd6:  begin tbl_adr = 8'd18; tbl_dat = acr_q[15:8];  end
                5'd7:  begin tbl_adr = 8'd19; tbl_dat = acr_q[7:0];   end
                5'd8:  begin tbl_adr = 8'd20; tbl_dat = amr_q[31:24]; end
                5'd9:  begin tbl_adr = 8'd21; tbl_dat = amr_q[23:16]; end
                5'd10: begin tbl_adr = 8'd22; tbl_dat = amr_q[15:8];  end
                5'd11: begin tbl_adr = 8'd23; tbl_dat = amr_q[7:0];   end
                5'd12: begin tbl_adr = 8'd0;  tbl_dat = {4'b0000, afm_q, 3'b000}; end
                default: begin tbl_adr = 8'h00; tbl_dat = 8'h00; end
            endcase
        end else begin
            case (next_step)
                5'd0:  begin tbl_adr = 8'd0;  tbl_dat = 8'h01;        end
                5'd1:  begin tbl_adr = 8'd31; tbl_dat = 8'h00;        end
                5'd2:  begin tbl_adr = 8'd6;  tbl_dat = btr0_q;       end
                5'd3:  begin tbl_adr = 8'd7;  tbl_dat = btr1_q;       end
                5'd4:  begin tbl_adr = 8'd4;  tbl_dat = acr_q[31:24]; end
                5'd5:  begin tbl_adr = 8'd5;  tbl_dat = amr_q[31:24]; end
                5'd6:  begin tbl_adr = 8'd0;  tbl_dat = 8'h00;        end
                default: begin tbl_adr = 8'h00; tbl_dat = 8'h00; end
            endcase
        end
    end

`ifdef CAN_CFG_VERIFY_EN
    // Both MODE writes are skipped: reading MODE back mid-transition is not meaningful
    assign need_rd = !rd_phase && (step != '0) && (step != last_step);
    assign rd_bad  = rd_phase && (wb_dat_i != wb_dat_o);
`else
    logic unused_rd;
    assign need_rd   = 1'b0;
    assign rd_bad    = 1'b0;
    assign unused_rd = ^{wb_dat_i, rd_phase};
`endif

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            step       <= '0;
            rd_phase   <= 1'b0;
            tmo_cnt    <= '0;
            ext_q      <= 1'b0;
            afm_q      <= 1'b0;
            btr0_q     <= 8'h00;
            btr1_q     <= 8'h00;
            acr_q      <= 32'h0;
            amr_q      <= 32'h0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_step_o <= 5'd0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= 8'h00;
            wb_dat_o   <= 8'h00;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ext_q      <= ext_mode_i;
                        afm_q      <= afm_i;
                        btr0_q     <= {sjw_i, brp_i};
                        btr1_q     <= {sam_i, tseg2_i, tseg1_i};
                        acr_q      <= acr_i;
                        amr_q      <= amr_i;
                        err_o      <= 1'b0;
                        err_step_o <= 5'd0;
                        busy_o     <= 1'b1;
                        step       <= '0;
                        rd_phase   <= 1'b0;
                        tmo_cnt    <= '0;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= 1'b1;
                        wb_adr_o   <= 8'd0;
                        wb_dat_o   <= 8'h01;
                        state      <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (wb_ack_i || (tmo_cnt == CNT_W'(TIMEOUT - 1))) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        tmo_cnt  <= '0;
                        if (wb_ack_i && !rd_bad) begin
                            state <= S_GAP;
                        end else begin
                            err_o      <= 1'b1;
                            err_step_o <= step;
                            busy_o     <= 1'b0;
                            state      <= S_ERR;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        state   <= S_WAIT;
                    end
                end
                S_GAP: begin
                    if (need_rd) begin
                        rd_phase <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        state    <= S_REQ;
                    end else if (step == last_step) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        rd_phase <= 1'b0;
                        step     <= next_step;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= tbl_adr;
                        wb_dat_o <= tbl_dat;
                        state    <= S_REQ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
